riscv_mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-ported, variable-latency memory between the core's instruction-fetch path and its load/store path. It sits between `riscv_cpu` and the unified memory. It serialises accesses with round-robin fairness and registers each request onto the memory bus. It returns each response as a one-cycle ready pulse and converts a non-responding memory into a bus error.

---
 rtl/riscv_mem_pkg.sv | 22 ++
 rtl/riscv_mem_arbiter_rr.sv | 24 ++
 rtl/riscv_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory arbiter and the instruction decoder:
// arbiter state encoding, requester port IDs and funct3 access sizes.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } memState_t;

    // Requester port identifiers, used for the owner and last-grant flops
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Access sizes use the RISC-V load/store funct3 encoding
    localparam logic [2:0] MEM_SIZE_B  = 3'b000;
    localparam logic [2:0] MEM_SIZE_H  = 3'b001;
    localparam logic [2:0] MEM_SIZE_W  = 3'b010;
    localparam logic [2:0] MEM_SIZE_BU = 3'b100;
    localparam logic [2:0] MEM_SIZE_HU = 3'b101;

endpackage

// File: rtl/riscv_mem_arbiter_rr.sv
// Combinational two-way round-robin grant between fetch and load/store.
// On a tie the port that was not granted last wins.
module rr_arbiter2
    import riscv_mem_pkg::*;
(
    input  logic iReq,
    input  logic dReq,
    input  logic last,
    output logic grantValid,
    output logic grantPort
);

    // Pick a port: the sole requester, or on a tie the one opposite to last
    always_comb begin
        grantValid = iReq | dReq;
        grantPort  = PORT_I;
        if (iReq && dReq) begin
            grantPort = ~last;
        end else if (dReq) begin
            grantPort = PORT_D;
        end
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and
// load/store paths. Each access is registered onto the memory bus, waits
// for MemAck (or aborts after TIMEOUT idle BUSY cycles, raising a sticky
// BusErr) and completes with a one-cycle Ready pulse to the owning port.
module riscv_mem_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic [DATA_W-1:0] IRData,
    output logic              IReady,
    input  logic              DReq,
    input  logic              DWE,
    input  logic [2:0]        DSize,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic [DATA_W-1:0] DRData,
    output logic              DReady,
    output logic              MemReq,
    output logic              MemWE,
    output logic [2:0]        MemSize,
    output logic [ADDR_W-1:0] MemA,
    output logic [DATA_W-1:0] MemWD,
    input  logic [DATA_W-1:0] MemRD,
    input  logic              MemAck,
    output logic              BusErr
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    memState_t         stateReg, stateNext;
    logic              ownerReg;
    logic              lastReg;
    logic [CNT_W-1:0]  cntReg;
    logic              busErrReg;
    logic              memWEReg;
    logic [2:0]        memSizeReg;
    logic [ADDR_W-1:0] memAReg;
    logic [DATA_W-1:0] memWDReg;

    logic grantValid;
    logic grantPort;
    logic grantTake;
    logic ackTake;
    logic abortTake;

    rr_arbiter2 uArb (
        .iReq       (IReq),
        .dReq       (DReq),
        .last       (lastReg),
        .grantValid (grantValid),
        .grantPort  (grantPort)
    );

    // Next state plus the grant / ack / abort strobes that drive the datapath
    always_comb begin
        stateNext = stateReg;
        grantTake = 1'b0;
        ackTake   = 1'b0;
        abortTake = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (grantValid) begin
                    grantTake = 1'b1;
                    stateNext = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Ack takes priority over a timeout landing in the same cycle
                if (MemAck) begin
                    ackTake   = 1'b1;
                    stateNext = ST_RESP;
                end else if (cntReg == CNT_MAX) begin
                    abortTake = 1'b1;
                    stateNext = ST_RESP;
                end
            end
            ST_RESP: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stateReg <= ST_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Latch the granted request onto the memory bus; fetches are word reads
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ownerReg   <= PORT_I;
            lastReg    <= PORT_D;
            memWEReg   <= 1'b0;
            memSizeReg <= '0;
            memAReg    <= '0;
            memWDReg   <= '0;
        end else if (grantTake) begin
            ownerReg <= grantPort;
            lastReg  <= grantPort;
            if (grantPort == PORT_D) begin
                memWEReg   <= DWE;
                memSizeReg <= DSize;
                memAReg    <= DAddr;
                memWDReg   <= DWData;
            end else begin
                memWEReg   <= 1'b0;
                memSizeReg <= MEM_SIZE_W;
                memAReg    <= IAddr;
                memWDReg   <= '0;
            end
        end
    end

    // Timeout counter: cleared on BUSY entry, counts un-acked BUSY cycles, saturates
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cntReg <= '0;
        end else if (grantTake) begin
            cntReg <= '0;
        end else if (stateReg == ST_BUSY && !MemAck && cntReg != CNT_MAX) begin
            cntReg <= cntReg + CNT_W'(1);
        end
    end

    // Sticky bus error, only reset clears it
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            busErrReg <= 1'b0;
        end else if (abortTake) begin
            busErrReg <= 1'b1;
        end
    end

    // One read-data holding register per port, updated only on that port's completion
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gRData
            localparam logic PORT_ID = (gi == 0) ? PORT_I : PORT_D;
            logic [DATA_W-1:0] dataReg;

            // Capture memory data on ack, or zero on abort, for the owning port
            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    dataReg <= '0;
                end else if ((ackTake || abortTake) && ownerReg == PORT_ID) begin
                    dataReg <= ackTake ? MemRD : '0;
                end
            end
        end
    endgenerate

    assign IRData  = gRData[0].dataReg;
    assign DRData  = gRData[1].dataReg;
    assign IReady  = (stateReg == ST_RESP) && (ownerReg == PORT_I);
    assign DReady  = (stateReg == ST_RESP) && (ownerReg == PORT_D);
    assign MemReq  = (stateReg == ST_BUSY);
    assign MemWE   = memWEReg;
    assign MemSize = memSizeReg;
    assign MemA    = memAReg;
    assign MemWD   = memWDReg;
    assign BusErr  = busErrReg;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: stimulus queues the expected bus
// request and the expected response; a memory model checks every BUSY cycle
// and answers after the queued delay; a monitor pops and checks each Ready.
module tb_riscv_mem_arbiter;

    localparam int TO = 6;

    logic        CLK;
    logic        RESET;
    logic        IReq;
    logic [31:0] IAddr;
    logic [31:0] IRData;
    logic        IReady;
    logic        DReq;
    logic        DWE;
    logic [2:0]  DSize;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic [31:0] DRData;
    logic        DReady;
    logic        MemReq;
    logic        MemWE;
    logic [2:0]  MemSize;
    logic [31:0] MemA;
    logic [31:0] MemWD;
    logic [31:0] MemRD;
    logic        MemAck;
    logic        BusErr;

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .IReq    (IReq),
        .IAddr   (IAddr),
        .IRData  (IRData),
        .IReady  (IReady),
        .DReq    (DReq),
        .DWE     (DWE),
        .DSize   (DSize),
        .DAddr   (DAddr),
        .DWData  (DWData),
        .DRData  (DRData),
        .DReady  (DReady),
        .MemReq  (MemReq),
        .MemWE   (MemWE),
        .MemSize (MemSize),
        .MemA    (MemA),
        .MemWD   (MemWD),
        .MemRD   (MemRD),
        .MemAck  (MemAck),
        .BusErr  (BusErr)
    );

    // dly: cycles after MemReq rises until MemAck (0 = ack in first BUSY cycle), -1 = never
    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          dly;
    } memExp_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          lat;
        logic        busErr;
    } respExp_t;

    memExp_t  memQ[$];
    respExp_t respQ[$];

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   riseCycle = 0;
    int   respCount = 0;
    logic strayAck = 1'b0;
    logic expBusErr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cycle++;
    end

    // Memory model: checks bus fields every BUSY cycle and acks after the queued delay
    initial begin
        memExp_t cur;
        int      busyCnt;
        logic    inBusy;
        inBusy  = 1'b0;
        busyCnt = 0;
        cur     = '{we: 1'b0, size: 3'b0, addr: 32'h0, wd: 32'h0, rd: 32'h0, dly: -1};
        MemAck  = 1'b0;
        MemRD   = 32'h0;
        forever begin
            @(negedge CLK);
            if (MemReq) begin
                if (!inBusy) begin
                    inBusy    = 1'b1;
                    busyCnt   = 0;
                    riseCycle = cycle;
                    if (memQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpectedMemReq actual MemA=%h required no request", MemA);
                        cur = '{we: MemWE, size: MemSize, addr: MemA, wd: MemWD, rd: 32'h0, dly: -1};
                    end else begin
                        cur = memQ.pop_front();
                    end
                end
                check("memWE", 32'(MemWE), 32'(cur.we));
                check("memSize", 32'(MemSize), 32'(cur.size));
                check("memA", MemA, cur.addr);
                check("memWD", MemWD, cur.wd);
                MemAck = (busyCnt == cur.dly);
                MemRD  = MemAck ? cur.rd : (32'hBAD0_0000 ^ 32'(busyCnt));
                busyCnt++;
            end else begin
                inBusy = 1'b0;
                MemAck = strayAck;
                MemRD  = 32'hFFFF_FFFF;
            end
        end
    end

    // Monitor: pops the scoreboard on each Ready and tracks the held read data
    initial begin
        respExp_t r;
        logic [31:0] expI;
        logic [31:0] expD;
        expI = 32'h0;
        expD = 32'h0;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                expI = 32'h0;
                expD = 32'h0;
            end else begin
                if (IReady || DReady) begin
                    check("readyOverlap", 32'(IReady & DReady), 32'h0);
                    if (respQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpectedReady actual I=%0b D=%0b required none", IReady, DReady);
                    end else begin
                        r = respQ.pop_front();
                        check("readyPort", 32'(DReady), 32'(r.port));
                        check("readyLatency", 32'(cycle - riseCycle), 32'(r.lat));
                        check("busErrAtReady", 32'(BusErr), 32'(r.busErr));
                        if (r.port) expD = r.data;
                        else        expI = r.data;
                        respCount++;
                    end
                end
                check("iRData", IRData, expI);
                check("dRData", DRData, expD);
            end
        end
    end

    task automatic waitResp(input int target);
        int n;
        n = 0;
        while (respCount < target && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (respCount < target) begin
            checks++;
            errors++;
            $display("FAIL respTimeout actual %0d responses required %0d", respCount, target);
        end
    endtask

    function automatic respExp_t mkResp(input logic port, input logic [31:0] rd, input int dly);
        respExp_t r;
        r.port   = port;
        r.data   = (dly < 0) ? 32'h0 : rd;
        r.lat    = (dly < 0) ? TO + 1 : dly + 1;
        r.busErr = expBusErr;
        return r;
    endfunction

    task automatic pushFetch(input logic [31:0] addr, input logic [31:0] rd, input int dly);
        memQ.push_back('{we: 1'b0, size: 3'b010, addr: addr, wd: 32'h0, rd: rd, dly: dly});
        respQ.push_back(mkResp(1'b0, rd, dly));
    endtask

    task automatic pushData(input logic we, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd, input int dly);
        memQ.push_back('{we: we, size: size, addr: addr, wd: wd, rd: rd, dly: dly});
        respQ.push_back(mkResp(1'b1, rd, dly));
    endtask

    task automatic fetch(input logic [31:0] addr, input logic [31:0] rd, input int dly);
        int target;
        target = respCount + 1;
        pushFetch(addr, rd, dly);
        IAddr = addr;
        IReq  = 1'b1;
        waitResp(target);
        IReq  = 1'b0;
        $display("txn fetch addr=%h dly=%0d", addr, dly);
    endtask

    task automatic dAccess(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int dly);
        int target;
        target = respCount + 1;
        pushData(we, size, addr, wd, rd, dly);
        DWE    = we;
        DSize  = size;
        DAddr  = addr;
        DWData = wd;
        DReq   = 1'b1;
        waitResp(target);
        DReq   = 1'b0;
        $display("txn data we=%0b size=%0d addr=%h dly=%0d", we, size, addr, dly);
    endtask

    initial begin
        int base;
        int n;
        RESET  = 1'b0;
        IReq   = 1'b0;
        IAddr  = 32'h0;
        DReq   = 1'b0;
        DWE    = 1'b0;
        DSize  = 3'b0;
        DAddr  = 32'h0;
        DWData = 32'h0;

        // Reset state
        #1;
        check("rstMemReq", 32'(MemReq), 32'h0);
        check("rstMemA", MemA, 32'h0);
        check("rstMemWE", 32'(MemWE), 32'h0);
        check("rstMemSize", 32'(MemSize), 32'h0);
        check("rstMemWD", MemWD, 32'h0);
        check("rstReady", 32'({IReady, DReady}), 32'h0);
        check("rstBusErr", 32'(BusErr), 32'h0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;

        // Contention from reset: fetch first, then store, alternating for 6 accesses
        base = respCount;
        IAddr  = 32'h0000_0104;
        DWE    = 1'b1;
        DSize  = 3'b001;
        DAddr  = 32'h0000_2000;
        DWData = 32'hDEAD_BEEF;
        pushFetch(32'h0000_0104, 32'h1111_0001, 0);
        pushData(1'b1, 3'b001, 32'h0000_2000, 32'hDEAD_BEEF, 32'h2222_0001, 1);
        pushFetch(32'h0000_0104, 32'h1111_0002, 0);
        pushData(1'b1, 3'b001, 32'h0000_2000, 32'hDEAD_BEEF, 32'h2222_0002, 2);
        pushFetch(32'h0000_0104, 32'h1111_0003, 1);
        pushData(1'b1, 3'b001, 32'h0000_2000, 32'hDEAD_BEEF, 32'h2222_0003, 0);
        IReq = 1'b1;
        DReq = 1'b1;
        waitResp(base + 6);
        IReq = 1'b0;
        DReq = 1'b0;
        $display("txn contention 6 accesses");
        @(negedge CLK);

        // Single minimum-latency fetch
        fetch(32'h0000_0100, 32'h0050_0093, 0);

        // Load with 5 wait states
        dAccess(1'b0, 3'b010, 32'h0000_2004, 32'h0, 32'h1234_5678, 5);

        // Ack arrives in the cycle the counter reaches TIMEOUT: data wins, no BusErr
        fetch(32'h0000_0108, 32'h00A0_0113, TO);

        // Stray acks while idle must not produce Ready or a bus request
        base = respCount;
        strayAck = 1'b1;
        repeat (3) @(negedge CLK);
        strayAck = 1'b0;
        repeat (2) @(negedge CLK);
        check("strayNoReady", 32'(respCount), 32'(base));
        check("strayNoMemReq", 32'(MemReq), 32'h0);
        $display("txn stray ack in idle");

        // Timeout on a load: zero data, sticky BusErr
        expBusErr = 1'b1;
        dAccess(1'b0, 3'b100, 32'h0000_3000, 32'h0, 32'h5555_AAAA, -1);
        check("busErrSticky", 32'(BusErr), 32'h1);

        // Following fetch completes normally with BusErr still set
        fetch(32'h0000_010C, 32'h0000_0013, 2);

        // Reset in the middle of a BUSY access
        memQ.push_back('{we: 1'b0, size: 3'b010, addr: 32'h0000_0400, wd: 32'h0, rd: 32'h0, dly: -1});
        IAddr = 32'h0000_0400;
        IReq  = 1'b1;
        n = 0;
        while (!MemReq && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("midRstReachedBusy", 32'(MemReq), 32'h1);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("midRstMemReq", 32'(MemReq), 32'h0);
        check("midRstReady", 32'({IReady, DReady}), 32'h0);
        check("midRstBusErr", 32'(BusErr), 32'h0);
        check("midRstIRData", IRData, 32'h0);
        IReq = 1'b0;
        expBusErr = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        base = respCount;
        repeat (4) @(negedge CLK);
        check("postRstIdle", 32'(MemReq), 32'h0);
        check("postRstNoReady", 32'(respCount), 32'(base));
        $display("txn reset mid-busy");

        // Normal operation after reset
        fetch(32'h0000_0200, 32'hCAFE_0001, 0);

        repeat (3) @(negedge CLK);
        check("scoreboardDrained", 32'(respQ.size() + memQ.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual time %0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
